// File: rtl/branch_ex.sv
// Branch/jump execute stage: resolves control transfers, pulses a fetch redirect
// on taken ops and buffers JAL/JALR link results until the CDB grants them.
`ifndef BRANCH_EX_OPCODES
`define BRANCH_EX_OPCODES
`define NOP  6'd0
`define JAL  6'd1
`define JALR 6'd2
`define BEQ  6'd3
`define BNE  6'd4
`define BLT  6'd5
`define BGE  6'd6
`define BLTU 6'd7
`define BGEU 6'd8
`endif

module branch_ex #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6,
  parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work_en,
  input  logic [DATA_W-1:0] operand_o,
  input  logic [DATA_W-1:0] operand_t,
  input  logic [DATA_W-1:0] imm,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [TAG_W-1:0]  dest_tag,
  input  logic              flush,
  input  logic              cdb_grant,
  output logic              busy,
  output logic              redirect_en,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              cdb_req,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              overrun
);

  typedef enum logic {EMPTY, PENDING} buf_state_e;

  buf_state_e        state_q, state_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              redirect_en_q, redirect_en_d;
  logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
  logic              overrun_q, overrun_d;

  logic              valid_op, is_link, taken, accept;
  logic [ADDR_W-1:0] target;

  assign busy = (state_q == PENDING) & ~cdb_grant;

  always_comb begin
    valid_op = (op != `NOP);
    is_link  = (op == `JAL) || (op == `JALR);
    taken    = 1'b0;
    target   = pc + ADDR_W'(imm);
    case (op)
      `JAL:  taken = 1'b1;
      `JALR: begin
        taken  = 1'b1;
        target = ADDR_W'(operand_o + imm) & ~ADDR_W'(1);
      end
      `BEQ:  taken = (operand_o == operand_t);
      `BNE:  taken = (operand_o != operand_t);
      `BLT:  taken = ($signed(operand_o) <  $signed(operand_t));
      `BGE:  taken = ($signed(operand_o) >= $signed(operand_t));
      `BLTU: taken = (operand_o <  operand_t);
      `BGEU: taken = (operand_o >= operand_t);
      default: taken = 1'b0;
    endcase
  end

  // Grant frees the buffer in the same cycle, so a new op may land with no bubble.
  assign accept = work_en & valid_op & ~flush & ~busy;

  always_comb begin
    state_d         = state_q;
    cdb_tag_d       = cdb_tag_q;
    cdb_data_d      = cdb_data_q;
    redirect_en_d   = accept & taken;
    redirect_addr_d = redirect_addr_q;
    overrun_d       = overrun_q | (work_en & valid_op & busy & ~flush);

    if (accept && taken)
      redirect_addr_d = target;

    if (flush) begin
      state_d   = EMPTY;
      cdb_tag_d = TAG_FREE;
    end else if (accept && is_link && dest_tag != TAG_FREE) begin
      state_d    = PENDING;
      cdb_tag_d  = dest_tag;
      cdb_data_d = DATA_W'(pc + ADDR_W'(4));
    end else if (state_q == PENDING && cdb_grant) begin
      state_d   = EMPTY;
      cdb_tag_d = TAG_FREE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= EMPTY;
      cdb_tag_q       <= TAG_FREE;
      cdb_data_q      <= '0;
      redirect_en_q   <= 1'b0;
      redirect_addr_q <= '0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cdb_tag_q       <= cdb_tag_d;
      cdb_data_q      <= cdb_data_d;
      redirect_en_q   <= redirect_en_d;
      redirect_addr_q <= redirect_addr_d;
      overrun_q       <= overrun_d;
    end
  end

  assign cdb_req       = (state_q == PENDING);
  assign cdb_tag       = cdb_tag_q;
  assign cdb_data      = cdb_data_q;
  assign redirect_en   = redirect_en_q;
  assign redirect_addr = redirect_addr_q;
  assign overrun       = overrun_q;

endmodule
